// File: rtl/stump_mem_arbiter_if.sv
// stump_mem_arbiter_if: core, debug and memory-side signals of the Stump memory arbiter
interface stump_mem_arbiter_if;
  logic c_req, c_wen, c_stall, c_done;
  logic [15:0] c_addr, c_wdata, c_rdata;
  logic d_req, d_wen, d_done;
  logic [15:0] d_addr, d_wdata, d_rdata;
  logic err, m_ren, m_wen, m_ready;
  logic [15:0] m_addr, m_wdata, m_rdata;
  modport slave (
    input c_req, c_wen, c_addr, c_wdata, d_req, d_wen, d_addr, d_wdata, m_rdata, m_ready,
    output c_stall, c_done, c_rdata, d_done, d_rdata, err, m_ren, m_wen, m_addr, m_wdata
  );
  modport master (
    output c_req, c_wen, c_addr, c_wdata, d_req, d_wen, d_addr, d_wdata, m_rdata, m_ready,
    input c_stall, c_done, c_rdata, d_done, d_rdata, err, m_ren, m_wen, m_addr, m_wdata
  );
endinterface

// File: rtl/stump_mem_arbiter.sv
// stump_mem_arbiter: sequences the single Stump memory port between core and debug requesters
module stump_mem_arbiter #(
  parameter int unsigned STARVE_LIMIT = 4,
  parameter int unsigned MAX_WAIT = 15
) (
  input logic clk,
  input logic rst,
  stump_mem_arbiter_if.slave bus
);
  typedef enum logic [1:0] {IDLE, XFER_C, XFER_D, DONE} state_t;
  state_t state_q, state_d;
  logic gnt_dbg_q, gnt_dbg_d;
  logic m_ren_q, m_ren_d, m_wen_q, m_wen_d, err_q, err_d;
  logic [15:0] m_addr_q, m_addr_d, m_wdata_q, m_wdata_d;
  logic [15:0] c_rdata_q, c_rdata_d, d_rdata_q, d_rdata_d, rd;
  logic [3:0] starve_q, starve_d;
  logic [7:0] wait_q, wait_d;
  logic pick_dbg, sel_wen, done_c;
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q   <= IDLE;
      gnt_dbg_q <= 1'b0;
      m_ren_q   <= 1'b0;
      m_wen_q   <= 1'b0;
      err_q     <= 1'b0;
      m_addr_q  <= '0;
      m_wdata_q <= '0;
      c_rdata_q <= '0;
      d_rdata_q <= '0;
      starve_q  <= '0;
      wait_q    <= '0;
    end else begin
      state_q   <= state_d;
      gnt_dbg_q <= gnt_dbg_d;
      m_ren_q   <= m_ren_d;
      m_wen_q   <= m_wen_d;
      err_q     <= err_d;
      m_addr_q  <= m_addr_d;
      m_wdata_q <= m_wdata_d;
      c_rdata_q <= c_rdata_d;
      d_rdata_q <= d_rdata_d;
      starve_q  <= starve_d;
      wait_q    <= wait_d;
    end
  end
  always_comb begin
    pick_dbg  = bus.d_req & (~bus.c_req | (starve_q == 4'(STARVE_LIMIT)));
    sel_wen   = pick_dbg ? bus.d_wen : bus.c_wen;
    rd        = bus.m_ready ? bus.m_rdata : '0;
    state_d   = state_q;
    gnt_dbg_d = gnt_dbg_q;
    m_ren_d   = m_ren_q;
    m_wen_d   = m_wen_q;
    err_d     = err_q;
    m_addr_d  = m_addr_q;
    m_wdata_d = m_wdata_q;
    c_rdata_d = c_rdata_q;
    d_rdata_d = d_rdata_q;
    starve_d  = starve_q;
    wait_d    = wait_q;
    case (state_q)
      IDLE: begin
        // a core win with d_req high is the only case that advances the starvation count
        starve_d = (pick_dbg | ~bus.d_req) ? '0 : starve_q + 4'd1;
        if (bus.c_req | bus.d_req) begin
          state_d   = pick_dbg ? XFER_D : XFER_C;
          gnt_dbg_d = pick_dbg;
          m_addr_d  = pick_dbg ? bus.d_addr : bus.c_addr;
          m_wdata_d = pick_dbg ? bus.d_wdata : bus.c_wdata;
          m_ren_d   = ~sel_wen;
          m_wen_d   = sel_wen;
          wait_d    = '0;
        end
      end
      XFER_C, XFER_D: begin
        if (bus.m_ready || wait_q == 8'(MAX_WAIT - 1)) begin
          state_d = DONE;
          m_ren_d = 1'b0;
          m_wen_d = 1'b0;
          err_d   = ~bus.m_ready;
          // writes keep old read data unless the transfer timed out
          if (!bus.m_ready || m_ren_q) begin
            c_rdata_d = gnt_dbg_q ? c_rdata_q : rd;
            d_rdata_d = gnt_dbg_q ? rd : d_rdata_q;
          end
        end else begin
          wait_d = wait_q + {7'd0, wait_q != 8'hFF};
        end
      end
      default: begin
        state_d = IDLE;
        err_d   = 1'b0;
      end
    endcase
  end
  always_comb begin
    done_c      = (state_q == DONE) & ~gnt_dbg_q;
    bus.c_done  = done_c;
    bus.d_done  = (state_q == DONE) & gnt_dbg_q;
    bus.c_stall = bus.c_req & ~done_c;
    bus.err     = err_q;
    bus.c_rdata = c_rdata_q;
    bus.d_rdata = d_rdata_q;
    bus.m_ren   = m_ren_q;
    bus.m_wen   = m_wen_q;
    bus.m_addr  = m_addr_q;
    bus.m_wdata = m_wdata_q;
  end
endmodule
